// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide, one step per clock,
// followed by a single sign-fixup cycle that commits the result.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             cpu_stall,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned DW = 2 * WIDTH;

  // op[2:1] selects the operation class, op[0] selects signed
  localparam logic [1:0] K_MUL  = 2'b00;
  localparam logic [1:0] K_DIV  = 2'b01;
  localparam logic [1:0] K_MADD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       kind_r;
  logic             neg_q_r;   // product / quotient must be negated
  logic             neg_r_r;   // remainder must be negated
  logic             dz_r;      // divide by zero latched at start
  logic [WIDTH-1:0] m_r;       // multiplicand / divisor magnitude
  logic [WIDTH-1:0] acc_r;     // high half of product / partial remainder
  logic [WIDTH-1:0] q_r;       // multiplier shifting out / quotient shifting in

  logic             op_legal_c;
  logic             accept_c;
  logic             a_neg_c;
  logic             b_neg_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic             dz_start_c;
  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH:0]   div_shift_c;
  logic [WIDTH:0]   div_diff_c;
  logic [DW-1:0]    prod_c;
  logic [DW-1:0]    prod_s_c;
  logic [DW-1:0]    madd_c;
  logic [WIDTH-1:0] quo_c;
  logic [WIDTH-1:0] rem_c;

  // Request decode: a legal start is only taken while not busy
  always_comb begin
    op_legal_c = (op[2:1] != 2'b11);
    accept_c   = start && op_legal_c && ((state == S_IDLE) || (state == S_DONE));
    a_neg_c    = op[0] && a[WIDTH-1];
    b_neg_c    = op[0] && b[WIDTH-1];
    a_mag_c    = a_neg_c ? WIDTH'(-a) : a;
    b_mag_c    = b_neg_c ? WIDTH'(-b) : b;
    dz_start_c = (op[2:1] == K_DIV) && (b == '0);
  end

  // One iteration step and the final sign correction
  always_comb begin
    mul_sum_c   = {1'b0, acc_r} + {1'b0, m_r & {WIDTH{q_r[0]}}};
    div_shift_c = {acc_r, q_r[WIDTH-1]};
    div_diff_c  = div_shift_c - {1'b0, m_r};
    prod_c      = {acc_r, q_r};
    prod_s_c    = neg_q_r ? DW'(-prod_c) : prod_c;
    madd_c      = {hi, lo} + prod_s_c;
    quo_c       = neg_q_r ? WIDTH'(-q_r) : q_r;
    rem_c       = neg_r_r ? WIDTH'(-acc_r) : acc_r;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept_c) state_nxt = dz_start_c ? S_FIX : S_CALC;
      end
      S_CALC: begin
        if (cnt == CNT_W'(1)) state_nxt = S_FIX;
      end
      S_FIX: begin
        state_nxt = S_DONE;
      end
      S_DONE: begin
        if (accept_c)        state_nxt = dz_start_c ? S_FIX : S_CALC;
        else if (!cpu_stall) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register with registered busy/done decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_CALC) || (state_nxt == S_FIX);
      done  <= (state_nxt == S_DONE);
    end
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      kind_r  <= K_MUL;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      dz_r    <= 1'b0;
      m_r     <= '0;
      acc_r   <= '0;
      q_r     <= '0;
    end else if (accept_c) begin
      cnt     <= dz_start_c ? '0 : CNT_W'(WIDTH);
      kind_r  <= op[2:1];
      neg_q_r <= a_neg_c ^ b_neg_c;
      neg_r_r <= a_neg_c;
      dz_r    <= dz_start_c;
      m_r     <= b_mag_c;
      acc_r   <= '0;
      q_r     <= dz_start_c ? a : a_mag_c;
    end else if (state == S_CALC) begin
      cnt <= cnt - CNT_W'(1);
      if (kind_r == K_DIV) begin
        if (!div_diff_c[WIDTH]) begin
          acc_r <= div_diff_c[WIDTH-1:0];
          q_r   <= {q_r[WIDTH-2:0], 1'b1};
        end else begin
          acc_r <= div_shift_c[WIDTH-1:0];
          q_r   <= {q_r[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_r <= mul_sum_c[WIDTH:1];
        q_r   <= {mul_sum_c[0], q_r[WIDTH-1:1]};
      end
    end
  end

  // HI/LO commit at FIX, software writes only while not busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else if (state == S_FIX) begin
      if (dz_r) begin
        hi       <= q_r;
        lo       <= '1;
        div_zero <= 1'b1;
      end else begin
        div_zero <= 1'b0;
        case (kind_r)
          K_DIV: begin
            hi <= rem_c;
            lo <= quo_c;
          end
          K_MADD: begin
            {hi, lo} <= madd_c;
          end
          default: begin
            {hi, lo} <= prod_s_c;
          end
        endcase
      end
    end else if ((state == S_IDLE) || (state == S_DONE)) begin
      if (wr_hi) hi <= wdata;
      if (wr_lo) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH = 32).
module tb_muldiv_unit;

  localparam logic [2:0] OP_MULU  = 3'b000;
  localparam logic [2:0] OP_MUL   = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MADDU = 3'b100;
  localparam logic [2:0] OP_MADD  = 3'b101;
  localparam logic [2:0] OP_ILL   = 3'b110;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wdata;
  logic        cpu_stall;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .wr_hi     (wr_hi),
    .wr_lo     (wr_lo),
    .wdata     (wdata),
    .cpu_stall (cpu_stall),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op (any pending wr_* rides on the start edge) and wait for done
  task automatic do_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input int lat);
    int   n;
    logic seen;
    logic busy1;
    op    = o;
    a     = av;
    b     = bv;
    start = 1'b1;
    n     = 0;
    seen  = 1'b0;
    busy1 = 1'b0;
    while (!seen && n < 200) begin
      tick();
      start = 1'b0;
      wr_hi = 1'b0;
      wr_lo = 1'b0;
      n++;
      if (n == 1) busy1 = busy;
      seen = done;
    end
    check_eq("busy_after_start", 64'(busy1), 64'(1));
    check_eq("latency", 64'(n), 64'(lat));
  endtask

  task automatic check_res(input string tag, input logic [31:0] eh, input logic [31:0] el,
                           input logic edz);
    check_eq({tag, "_hi"}, 64'(hi), 64'(eh));
    check_eq({tag, "_lo"}, 64'(lo), 64'(el));
    check_eq({tag, "_dz"}, 64'(div_zero), 64'(edz));
  endtask

  initial begin
    int   n;
    logic seen;
    rst       = 1'b0;
    start     = 1'b0;
    op        = OP_MULU;
    a         = '0;
    b         = '0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    wdata     = '0;
    cpu_stall = 1'b0;
    tick();
    tick();
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_res("rst", 32'h0, 32'h0, 1'b0);

    // first start lands on the first edge after release
    rst = 1'b1;
    do_op(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    check_res("mulu_max", 32'hFFFFFFFE, 32'h00000001, 1'b0);

    do_op(OP_MUL, 32'hFFFFFFFE, 32'h00000003, 34);
    check_res("mul_neg", 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);

    do_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 34);
    check_res("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);

    do_op(OP_DIVU, 32'h00000064, 32'h00000000, 2);
    check_res("divu_zero", 32'h00000064, 32'hFFFFFFFF, 1'b1);

    do_op(OP_MULU, 32'h00000003, 32'h00000005, 34);
    check_res("mulu_clr_dz", 32'h00000000, 32'h0000000F, 1'b0);

    do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 34);
    check_res("div_ovf", 32'h00000000, 32'h80000000, 1'b0);

    do_op(OP_DIV, 32'h00000007, 32'hFFFFFFFE, 34);
    check_res("div_negb", 32'h00000001, 32'hFFFFFFFD, 1'b0);

    do_op(OP_DIVU, 32'h00000064, 32'h00000007, 34);
    check_res("divu", 32'h00000002, 32'h0000000E, 1'b0);

    // software writes from IDLE
    tick();
    wr_hi = 1'b1;
    wdata = 32'h12345678;
    tick();
    wr_hi = 1'b0;
    check_eq("mthi", 64'(hi), 64'h12345678);
    check_eq("mthi_lo_kept", 64'(lo), 64'h0000000E);
    wr_lo = 1'b1;
    wdata = 32'h9ABCDEF0;
    tick();
    wr_lo = 1'b0;
    check_eq("mtlo", 64'(lo), 64'h9ABCDEF0);

    // write and start on the same edge; accumulate uses written value
    wr_hi = 1'b1;
    wr_lo = 1'b1;
    wdata = 32'h00000001;
    do_op(OP_MADDU, 32'h00000002, 32'h00000003, 34);
    check_res("maddu", 32'h00000001, 32'h00000007, 1'b0);

    do_op(OP_MADD, 32'hFFFFFFFF, 32'h00000002, 34);
    check_res("madd_neg", 32'h00000001, 32'h00000005, 1'b0);

    // illegal opcode from IDLE is ignored
    tick();
    op    = OP_ILL;
    a     = 32'h00000011;
    b     = 32'h00000022;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("ill_busy", 64'(busy), 64'(0));
    check_eq("ill_done", 64'(done), 64'(0));
    check_res("ill", 32'h00000001, 32'h00000005, 1'b0);

    // stall holds done; start/write while busy ignored
    cpu_stall = 1'b1;
    op    = OP_MULU;
    a     = 32'h00000006;
    b     = 32'h00000007;
    start = 1'b1;
    n     = 0;
    seen  = 1'b0;
    while (!seen && n < 200) begin
      tick();
      start = 1'b0;
      wr_hi = 1'b0;
      n++;
      if (n == 5) begin
        start = 1'b1;
        op    = OP_MULU;
        a     = 32'h00000009;
        b     = 32'h00000009;
        wr_hi = 1'b1;
        wdata = 32'h0000DEAD;
      end
      seen = done;
    end
    check_eq("stall_latency", 64'(n), 64'(34));
    check_res("stall_res", 32'h00000000, 32'h0000002A, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_done", 64'(done), 64'(1));
      check_eq("stall_hi", 64'(hi), 64'h0);
      check_eq("stall_lo", 64'(lo), 64'h2A);
    end
    cpu_stall = 1'b0;
    tick();
    check_eq("unstall_done", 64'(done), 64'(0));

    // reset in the middle of a divide
    op    = OP_DIV;
    a     = 32'hFFFFFF9C;
    b     = 32'h00000003;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b0;
    #1;
    check_eq("mid_rst_busy", 64'(busy), 64'(0));
    check_eq("mid_rst_done", 64'(done), 64'(0));
    check_res("mid_rst", 32'h0, 32'h0, 1'b0);
    tick();
    rst  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check_eq("no_done_after_rst", 64'(seen), 64'(0));

    do_op(OP_DIV, 32'hFFFFFF9C, 32'h00000003, 34);
    check_res("div_after_rst", 32'hFFFFFFFF, 32'hFFFFFFDF, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
